// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings, BTB entry layout
// and the PC index/tag split.
package branch_pred_pkg;

    // Entry fields are sized for the widest supported PC. Narrower PCs are zero-extended.
    localparam int unsigned BP_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_MAX_WIDTH-1:0] tag;
        logic [BP_MAX_WIDTH-1:0] target;
        ctr_e                    ctr;
    } btb_entry_t;

    function automatic int unsigned bp_index(input logic [BP_MAX_WIDTH-1:0] pc,
                                             input int unsigned idx);
        logic [BP_MAX_WIDTH-1:0] w_mask;
        w_mask = (BP_MAX_WIDTH'(1) << idx) - BP_MAX_WIDTH'(1);
        return 32'((pc >> 2) & w_mask);
    endfunction

    function automatic logic [BP_MAX_WIDTH-1:0] bp_tag(input logic [BP_MAX_WIDTH-1:0] pc,
                                                      input int unsigned idx);
        return pc >> (idx + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the pipeline and the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] PCF;
    logic             PredTakenF;
    logic [WIDTH-1:0] PredTargetF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             BranchE;
    logic             ActualTakenE;
    logic [WIDTH-1:0] PCE;
    logic [WIDTH-1:0] PCPlus4E;
    logic [WIDTH-1:0] BranchTargetE;
    logic             MispredictE;
    logic [WIDTH-1:0] RedirectPCE;
    logic [WIDTH-1:0] BranchCount;
    logic [WIDTH-1:0] MispredictCount;

    modport slave (
        input  PCF, StallD, FlushD, FlushE, BranchE, ActualTakenE,
               PCE, PCPlus4E, BranchTargetE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );

    modport master (
        output PCF, StallD, FlushD, FlushE, BranchE, ActualTakenE,
               PCE, PCPlus4E, BranchTargetE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE,
               BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic for a 2-bit saturating branch direction counter.
module sat_counter_2b
    import branch_pred_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != ST) ctr_next = ctr_e'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) ctr_next = ctr_e'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch-stage lookup, prediction carried to
// Execute, misprediction detection/redirect and resolution-time update.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_predictor_if.slave  bp
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    btb_entry_t              r_btb [ENTRIES];
    logic                    r_pred_taken_d;
    logic [WIDTH-1:0]        r_pred_target_d;
    logic                    r_pred_taken_e;
    logic [WIDTH-1:0]        r_pred_target_e;
    logic [WIDTH-1:0]        r_branch_cnt;
    logic [WIDTH-1:0]        r_mispredict_cnt;

    logic [IDX-1:0]          w_idx_f;
    logic [BP_MAX_WIDTH-1:0] w_tag_f;
    btb_entry_t              w_ent_f;
    logic                    w_hit_f;
    logic                    w_pred_taken_f;
    logic [WIDTH-1:0]        w_pred_target_f;

    logic [IDX-1:0]          w_idx_u;
    logic [BP_MAX_WIDTH-1:0] w_tag_u;
    btb_entry_t              w_ent_u;
    logic                    w_hit_u;
    ctr_e                    w_ctr_next;
    logic                    w_mispredict;

    assign w_idx_f = IDX'(bp_index(BP_MAX_WIDTH'(bp.PCF), IDX));
    assign w_tag_f = bp_tag(BP_MAX_WIDTH'(bp.PCF), IDX);
    assign w_idx_u = IDX'(bp_index(BP_MAX_WIDTH'(bp.PCE), IDX));
    assign w_tag_u = bp_tag(BP_MAX_WIDTH'(bp.PCE), IDX);

    always_comb begin
        w_ent_f         = r_btb[w_idx_f];
        w_hit_f         = w_ent_f.valid && (w_ent_f.tag == w_tag_f);
        w_pred_taken_f  = w_hit_f && w_ent_f.ctr[1];
        w_pred_target_f = w_pred_taken_f ? WIDTH'(w_ent_f.target) : '0;
    end

    always_comb begin
        w_ent_u = r_btb[w_idx_u];
        w_hit_u = w_ent_u.valid && (w_ent_u.tag == w_tag_u);
    end

    sat_counter_2b u_sat_counter (
        .ctr      (w_ent_u.ctr),
        .taken    (bp.ActualTakenE),
        .ctr_next (w_ctr_next)
    );

    // A taken prediction with no branch in Execute means the entry is stale.
    always_comb begin
        w_mispredict = 1'b0;
        if (bp.BranchE) begin
            w_mispredict = (bp.ActualTakenE != r_pred_taken_e) ||
                           (bp.ActualTakenE && (r_pred_target_e != bp.BranchTargetE));
        end else if (r_pred_taken_e) begin
            w_mispredict = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (bp.BranchE) begin
            if (w_hit_u) begin
                r_btb[w_idx_u].ctr <= w_ctr_next;
                if (bp.ActualTakenE) r_btb[w_idx_u].target <= BP_MAX_WIDTH'(bp.BranchTargetE);
            end else if (bp.ActualTakenE) begin
                r_btb[w_idx_u] <= '{valid: 1'b1, tag: w_tag_u,
                                    target: BP_MAX_WIDTH'(bp.BranchTargetE), ctr: WT};
            end
        end else if (r_pred_taken_e) begin
            r_btb[w_idx_u].valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pred_taken_d  <= 1'b0;
            r_pred_target_d <= '0;
            r_pred_taken_e  <= 1'b0;
            r_pred_target_e <= '0;
        end else begin
            if (bp.FlushD) begin
                r_pred_taken_d  <= 1'b0;
                r_pred_target_d <= '0;
            end else if (!bp.StallD) begin
                r_pred_taken_d  <= w_pred_taken_f;
                r_pred_target_d <= w_pred_target_f;
            end
            if (bp.FlushE) begin
                r_pred_taken_e  <= 1'b0;
                r_pred_target_e <= '0;
            end else begin
                r_pred_taken_e  <= r_pred_taken_d;
                r_pred_target_e <= r_pred_target_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (bp.BranchE && (r_branch_cnt != '1)) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispredict && (r_mispredict_cnt != '1)) r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
        end
    end

    assign bp.PredTakenF      = w_pred_taken_f;
    assign bp.PredTargetF     = w_pred_target_f;
    assign bp.MispredictE     = w_mispredict;
    assign bp.RedirectPCE     = (bp.BranchE && bp.ActualTakenE) ? bp.BranchTargetE : bp.PCPlus4E;
    assign bp.BranchCount     = r_branch_cnt;
    assign bp.MispredictCount = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    localparam logic [31:0] PC_MISS = 32'h100;

    logic clk;
    logic reset;
    int unsigned n_cmp;
    int unsigned n_err;

    branch_predictor_if #(.WIDTH(32)) bus ();

    branch_predictor #(.WIDTH(32), .ENTRIES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exe(input logic br, input logic tk, input logic [31:0] pce,
                       input logic [31:0] tgt);
        bus.BranchE       = br;
        bus.ActualTakenE  = tk;
        bus.PCE           = pce;
        bus.PCPlus4E      = pce + 32'd4;
        bus.BranchTargetE = tgt;
    endtask

    task automatic check_pred(input string tag, input logic tk, input logic [31:0] tgt);
        #1;
        check({tag, "_taken"}, {31'b0, bus.PredTakenF}, {31'b0, tk});
        check({tag, "_target"}, bus.PredTargetF, tgt);
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] b, input logic [31:0] m);
        check({tag, "_bcnt"}, bus.BranchCount, b);
        check({tag, "_mcnt"}, bus.MispredictCount, m);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.PCF = PC_MISS;
        bus.StallD = 1'b0;
        bus.FlushD = 1'b0;
        bus.FlushE = 1'b0;
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_cnt("reset", 32'd0, 32'd0);
        check("reset_mis", {31'b0, bus.MispredictE}, 32'd0);

        for (int unsigned a = 0; a <= 32'h3C; a += 4) begin
            bus.PCF = a;
            check_pred("sweep", 1'b0, 32'h0);
        end

        // Cold taken branch 0x20 -> 0x80 allocates the entry.
        bus.PCF = PC_MISS;
        exe(1'b1, 1'b1, 32'h20, 32'h80);
        #1;
        check("alloc_mis", {31'b0, bus.MispredictE}, 32'd1);
        check("alloc_redir", bus.RedirectPCE, 32'h80);
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h20;
        check_pred("alloc_lookup", 1'b1, 32'h80);
        check_cnt("alloc", 32'd1, 32'd1);

        // Fetch 0x20 down the pipe, then resolve not-taken three times.
        tick();
        bus.PCF = PC_MISS;
        tick();
        exe(1'b1, 1'b0, 32'h20, 32'h80);
        #1;
        check("nt1_mis", {31'b0, bus.MispredictE}, 32'd1);
        check("nt1_redir", bus.RedirectPCE, 32'h24);
        tick();
        #1;
        check("nt2_mis", {31'b0, bus.MispredictE}, 32'd0);
        tick();
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h20;
        check_pred("nt_lookup", 1'b0, 32'h0);
        check_cnt("nt", 32'd4, 32'd2);

        // Three taken resolutions climb 00 -> 11.
        bus.PCF = PC_MISS;
        exe(1'b1, 1'b1, 32'h20, 32'h80);
        repeat (3) tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h20;
        check_pred("climb_lookup", 1'b1, 32'h80);
        check_cnt("climb", 32'd7, 32'd5);

        // Predicted 0x80, resolves to 0x90.
        tick();
        bus.PCF = PC_MISS;
        tick();
        exe(1'b1, 1'b1, 32'h20, 32'h90);
        #1;
        check("tgt_mis", {31'b0, bus.MispredictE}, 32'd1);
        check("tgt_redir", bus.RedirectPCE, 32'h90);
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h20;
        check_pred("tgt_lookup", 1'b1, 32'h90);
        check_cnt("tgt", 32'd8, 32'd6);

        // FlushD squashes the prediction before it reaches Execute.
        bus.FlushD = 1'b1;
        tick();
        bus.FlushD = 1'b0;
        bus.PCF = PC_MISS;
        tick();
        #1;
        check("flushd_mis", {31'b0, bus.MispredictE}, 32'd0);

        // StallD holds the prediction for 2 cycles while Execute takes bubbles.
        bus.PCF = 32'h20;
        tick();
        bus.PCF = PC_MISS;
        bus.StallD = 1'b1;
        bus.FlushE = 1'b1;
        repeat (2) tick();
        bus.StallD = 1'b0;
        bus.FlushE = 1'b0;
        tick();
        exe(1'b1, 1'b1, 32'h20, 32'h90);
        #1;
        check("stall_mis", {31'b0, bus.MispredictE}, 32'd0);
        check("stall_redir", bus.RedirectPCE, 32'h90);
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_cnt("stall", 32'd9, 32'd6);

        // Taken prediction meets a non-branch: redirect to fall-through, invalidate.
        bus.PCF = 32'h20;
        tick();
        bus.PCF = PC_MISS;
        tick();
        exe(1'b0, 1'b0, 32'h20, 32'hDEAD);
        #1;
        check("stale_mis", {31'b0, bus.MispredictE}, 32'd1);
        check("stale_redir", bus.RedirectPCE, 32'h24);
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h20;
        check_pred("stale_lookup", 1'b0, 32'h0);
        check_cnt("stale", 32'd9, 32'd7);

        // Build some state, then reset overrides a concurrent allocation.
        bus.PCF = PC_MISS;
        exe(1'b1, 1'b1, 32'h30, 32'h44);
        tick();
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        bus.PCF = 32'h30;
        check_pred("pre_rst_lookup", 1'b1, 32'h44);
        check_cnt("pre_rst", 32'd10, 32'd8);
        tick();
        reset = 1'b1;
        exe(1'b1, 1'b1, 32'h34, 32'h50);
        tick();
        reset = 1'b0;
        exe(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_cnt("mid_rst", 32'd0, 32'd0);
        check("mid_rst_mis", {31'b0, bus.MispredictE}, 32'd0);
        bus.PCF = 32'h30;
        check_pred("mid_rst_30", 1'b0, 32'h0);
        bus.PCF = 32'h34;
        check_pred("mid_rst_34", 1'b0, 32'h0);
        bus.PCF = PC_MISS;
        tick();
        #1;
        check("mid_rst_pipe", {31'b0, bus.MispredictE}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
